// File: rtl/pix_pair_packer_if.sv
// rtl/pix_pair_packer_if.sv - pixel-in / pair-out handshake bundle for pix_pair_packer
interface pix_pair_packer_if;
  logic [17:0] pixel_in;
  logic        pixel_valid;
  logic        line_start;
  logic        frame_start;
  logic        pair_ready;
  logic        pair_valid;
  logic [35:0] two_pixel_vals;
  logic [18:0] write_addr;
  logic        overflow;

  modport master (
    output pixel_in, pixel_valid, line_start, frame_start, pair_ready,
    input  pair_valid, two_pixel_vals, write_addr, overflow
  );

  modport slave (
    input  pixel_in, pixel_valid, line_start, frame_start, pair_ready,
    output pair_valid, two_pixel_vals, write_addr, overflow
  );
endinterface

// File: rtl/pix_pair_packer.sv
// rtl/pix_pair_packer.sv - packs 18-bit pixels into addressed 36-bit pairs behind a small FIFO
// Optional drop_cnt output enabled by PACK_DROP_CNT_EN.
module pix_pair_packer #(
  parameter int H_PAIRS    = 320,
  parameter int V_LINES    = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  pix_pair_packer_if.slave  bus
`ifdef PACK_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int ADDR_W = 19;
  localparam int COL_W  = $clog2(H_PAIRS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PAIRS);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PAIRS);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  // armed stays low after reset until a frame_start, so a mid-frame reset
  // cannot produce pairs with stale addressing
  logic              armed;
  logic              half_valid;
  logic [17:0]       half_pix;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] addr;
  logic              overflow_q;

  logic [35:0]       fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic accept;
  logic pair_done;
  logic pos_drop;
  logic push_req;
  logic push_ok;
  logic fifo_drop;
  logic any_drop;
  logic pop;
  logic full;

  always_comb begin
    accept    = 1'b0;
    pair_done = 1'b0;
    pos_drop  = 1'b0;
    push_req  = 1'b0;
    full      = (count == CNT_FULL);
    pop       = (count != '0) && bus.pair_ready;
    accept    = bus.pixel_valid && (bus.frame_start || armed);
    pair_done = accept && !bus.frame_start && !bus.line_start && half_valid;
    if (pair_done) begin
      if (col == COL_MAX || line == LINE_MAX) begin
        pos_drop = 1'b1;
      end else begin
        push_req = 1'b1;
      end
    end
    push_ok   = push_req && (!full || pop);
    fifo_drop = push_req && !push_ok;
    any_drop  = pos_drop || fifo_drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      half_valid <= 1'b0;
      half_pix   <= '0;
      col        <= '0;
      line       <= '0;
      line_base  <= '0;
      addr       <= '0;
    end else if (accept) begin
      if (bus.frame_start) begin
        armed      <= 1'b1;
        half_valid <= 1'b1;
        half_pix   <= bus.pixel_in;
        col        <= '0;
        line       <= '0;
        line_base  <= '0;
        addr       <= '0;
      end else if (bus.line_start) begin
        half_valid <= 1'b1;
        half_pix   <= bus.pixel_in;
        col        <= '0;
        if (line == LINE_LAST) begin
          line <= LINE_MAX;
        end else if (line != LINE_MAX) begin
          line      <= line + 1'b1;
          line_base <= line_base + LINE_STEP;
          addr      <= line_base + LINE_STEP;
        end
      end else if (half_valid) begin
        half_valid <= 1'b0;
        // position advances even when the FIFO drops the pair
        if (col != COL_MAX && line != LINE_MAX) begin
          col  <= col + 1'b1;
          addr <= addr + 1'b1;
        end
      end else begin
        half_valid <= 1'b1;
        half_pix   <= bus.pixel_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (accept && bus.frame_start) begin
      overflow_q <= 1'b0;
    end else if (any_drop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef PACK_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (accept && bus.frame_start) begin
      drop_cnt <= '0;
    end else if (any_drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        fifo_data[wr_ptr] <= {half_pix, bus.pixel_in};
        fifo_addr[wr_ptr] <= addr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.pair_valid     = (count != '0);
  assign bus.two_pixel_vals = fifo_data[rd_ptr];
  assign bus.write_addr     = fifo_addr[rd_ptr];
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_pix_pair_packer.sv
// tb/tb_pix_pair_packer.sv - scoreboard bench for pix_pair_packer
module tb_pix_pair_packer;
  logic clk;
  logic reset;
  pix_pair_packer_if bus ();
`ifdef PACK_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pix_pair_packer #(.H_PAIRS(320), .V_LINES(480), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef PACK_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [54:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_drops(input string tag, input int exp);
`ifdef PACK_DROP_CNT_EN
    chk(tag, drop_cnt, exp);
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  function automatic logic [17:0] rnd18();
    return 18'($urandom());
  endfunction

  task automatic px(input logic [17:0] p, input logic ls, input logic fs);
    bus.pixel_in    = p;
    bus.pixel_valid = 1'b1;
    bus.line_start  = ls;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    bus.line_start  = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  // drives a two-pixel pair; a nonzero expect flag queues the packed result
  task automatic pair(input logic ls, input logic fs, input logic [18:0] a, input logic expect_it);
    logic [17:0] p0;
    logic [17:0] p1;
    p0 = rnd18();
    p1 = rnd18();
    px(p0, ls, fs);
    px(p1, 1'b0, 1'b0);
    if (expect_it) exp_q.push_back({p0, p1, a});
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.pair_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.pair_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", n < 3000, 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.pair_valid && bus.pair_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", bus.write_addr, 19'h7FFFF);
      end else begin
        logic [54:0] e;
        e = exp_q.pop_front();
        chk("pair_data", bus.two_pixel_vals, e[54:19]);
        chk("pair_addr", bus.write_addr, e[18:0]);
      end
    end
  end

  initial begin
    logic [17:0] a;
    logic [17:0] b;
    reset           = 1'b1;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.line_start  = 1'b0;
    bus.frame_start = 1'b0;
    bus.pair_ready  = 1'b0;
    #3;
    chk("rst_valid", bus.pair_valid, 0);
    chk("rst_data", bus.two_pixel_vals, 0);
    chk("rst_addr", bus.write_addr, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk_drops("rst_drops", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // first pair latency and packing order
    px(18'h00001, 1'b0, 1'b1);
    px(18'h00002, 1'b0, 1'b0);
    chk("t1_valid", bus.pair_valid, 1);
    chk("t1_data", bus.two_pixel_vals, 36'h000040002);
    chk("t1_addr", bus.write_addr, 0);
    exp_q.push_back({36'h000040002, 19'd0});
    drain();

    // two full lines streamed back to back
    bus.pair_ready = 1'b1;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 320; c++) begin
        pair(l == 1 && c == 0, l == 0 && c == 0, 19'(l * 320 + c), 1'b1);
      end
    end
    chk("t2_ovf", bus.overflow, 0);
    drain();

    // odd pixel discarded by line_start
    pair(1'b0, 1'b1, 19'd0, 1'b1);
    pair(1'b1, 1'b0, 19'd320, 1'b1);
    px(rnd18(), 1'b0, 1'b0);
    pair(1'b1, 1'b0, 19'd640, 1'b1);
    pair(1'b0, 1'b0, 19'd641, 1'b1);
    chk("t3_ovf", bus.overflow, 0);
    drain();

    // FIFO overflow with downstream stalled
    bus.pair_ready = 1'b0;
    for (int i = 0; i < 5; i++) pair(1'b0, i == 0, 19'(i), i < 4);
    chk("t4_ovf_set", bus.overflow, 1);
    chk_drops("t4_drops", 1);
    drain();
    a = rnd18();
    px(a, 1'b0, 1'b1);
    chk("t4_ovf_clr", bus.overflow, 0);
    chk_drops("t4_drops_clr", 0);
    b = rnd18();
    px(b, 1'b0, 1'b0);
    exp_q.push_back({a, b, 19'd0});
    drain();

    // push into a full FIFO while popping
    bus.pair_ready = 1'b0;
    for (int i = 0; i < 4; i++) pair(1'b0, i == 0, 19'(i), 1'b1);
    a = rnd18();
    b = rnd18();
    px(a, 1'b0, 1'b0);
    bus.pair_ready = 1'b1;
    px(b, 1'b0, 1'b0);
    bus.pair_ready = 1'b0;
    exp_q.push_back({a, b, 19'd4});
    chk("t5_ovf", bus.overflow, 0);
    chk("t5_valid", bus.pair_valid, 1);
    bus.pair_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.pair_ready = 1'b0;
    chk("t5_empty", bus.pair_valid, 0);
    chk("t5_sb", exp_q.size(), 0);

    // asynchronous reset mid-line with entries queued
    for (int i = 0; i < 3; i++) pair(1'b0, i == 0, 19'(i), 1'b1);
    px(rnd18(), 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", bus.pair_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.pair_ready = 1'b1;
    px(rnd18(), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) px(rnd18(), 1'b0, 1'b0);
    chk("t6_ignored", bus.pair_valid, 0);
    pair(1'b0, 1'b1, 19'd0, 1'b1);
    drain();

    // column overrun: 322 pairs on one line
    for (int c = 0; c < 322; c++) pair(1'b0, c == 0, 19'(c), c < 320);
    chk("t7_ovf", bus.overflow, 1);
    chk_drops("t7_drops", 2);
    drain();

    // line overrun: one pair per line across a whole frame and one beyond
    for (int l = 0; l < 480; l++) pair(l != 0, l == 0, 19'(l * 320), 1'b1);
    chk("t8_ovf_clear", bus.overflow, 0);
    pair(1'b1, 1'b0, 19'd0, 1'b0);
    pair(1'b0, 1'b0, 19'd0, 1'b0);
    chk("t8_ovf_set", bus.overflow, 1);
    chk_drops("t8_drops", 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
